apb_master_arbiter: RTL

- Shares one APB master port between N_REQ local requesters.
- Each requester posts a single read or write. The block arbitrates round-robin and drives the APB SETUP/ACCESS sequence toward a slave such as apb_slave.
- Completion handling: waits on PREADY, then returns read data and PSLVERR to the winning requester with a one-cycle done pulse.
- Sits between CPU/DMA-style requesters and the APB peripheral bus.

---
 rtl/apb_pkg.sv | 13 +
 rtl/apb_master_arbiter_rr_arbiter.sv | 27 ++
 rtl/apb_master_arbiter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// APB state encoding and bus widths, shared by apb_master_arbiter and apb_slave.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

endpackage

// File: rtl/apb_master_arbiter_rr_arbiter.sv
// Round-robin picker: first requesting index at or above ptr_i, wrapping.
module rr_arbiter #(
    parameter int N_REQ = 2,
    localparam int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N_REQ-1:0] gnt_o
);

    logic found;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            for (int j = 0; j < N_REQ; j++) begin
                if (!found && req_i[j] &&
                    j == (int'(ptr_i) + i) % N_REQ) begin
                    gnt_o[j] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// N_REQ requesters sharing one APB master port, round-robin arbitrated.
// Define APB_ARB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES without PREADY.
module apb_master_arbiter
    import apb_pkg::*;
#(
    parameter int N_REQ          = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                        i_clk,
    input  logic                        i_reset_n,
    input  logic [N_REQ-1:0]            i_req,
    input  logic [N_REQ-1:0]            i_write,
    input  logic [APB_ADDR_W*N_REQ-1:0] i_addr,
    input  logic [APB_DATA_W*N_REQ-1:0] i_wdata,
    output logic [N_REQ-1:0]            o_gnt,
    output logic [N_REQ-1:0]            o_done,
    output logic [APB_DATA_W-1:0]       o_rdata,
    output logic                        o_err,
    output logic [APB_ADDR_W-1:0]       PADDR,
    output logic                        PWRITE,
    output logic [APB_DATA_W-1:0]       PWDATA,
    output logic                        PSELx,
    output logic                        PENABLE,
    input  logic [APB_DATA_W-1:0]       PRDATA,
    input  logic                        PREADY,
    input  logic                        PSLVERR
);

    localparam int PTR_W = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("apb_master_arbiter: unsupported parameter values");
    end

    state_t                  state_q;
    logic [PTR_W-1:0]        ptr_q, own_q, ptr_nxt;
    logic [N_REQ-1:0]        gnt_q, done_q, arb_gnt;
    logic [APB_DATA_W-1:0]   rdata_q, pwdata_q, end_rdata;
    logic [APB_ADDR_W-1:0]   paddr_q;
    logic                    err_q, pwrite_q, psel_q, penable_q;
    logic [PTR_W-1:0]        sel_idx;
    logic [APB_ADDR_W-1:0]   sel_addr;
    logic [APB_DATA_W-1:0]   sel_wdata;
    logic                    sel_write, xfer_end, end_err;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q;
    logic             tmo_hit;
    assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
`endif

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req_i (i_req),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt)
    );

    always_comb begin
        sel_idx   = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_write = 1'b0;
        for (int j = 0; j < N_REQ; j++) begin
            if (arb_gnt[j]) begin
                sel_idx   = PTR_W'(j);
                sel_addr  = i_addr[j*APB_ADDR_W +: APB_ADDR_W];
                sel_wdata = i_wdata[j*APB_DATA_W +: APB_DATA_W];
                sel_write = i_write[j];
            end
        end
    end

    assign ptr_nxt = (own_q == PTR_W'(N_REQ - 1)) ? '0 : own_q + 1'b1;

    // A transfer ends on PREADY, or on timeout when that is built in.
    always_comb begin
        xfer_end  = 1'b0;
        end_rdata = '0;
        end_err   = 1'b0;
        if (state_q == ACCESS) begin
            if (PREADY) begin
                xfer_end  = 1'b1;
                end_rdata = pwrite_q ? '0 : PRDATA;
                end_err   = PSLVERR;
            end
`ifdef APB_ARB_TIMEOUT_EN
            else if (tmo_hit) begin
                xfer_end = 1'b1;
                end_err  = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            own_q     <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
            tmo_q     <= '0;
`endif
        end else begin
            done_q <= '0;
            unique case (state_q)
                IDLE: begin
                    if (|i_req) begin
                        own_q    <= sel_idx;
                        gnt_q    <= arb_gnt;
                        paddr_q  <= sel_addr;
                        pwrite_q <= sel_write;
                        pwdata_q <= sel_wdata;
                        psel_q   <= 1'b1;
                        state_q  <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
                    tmo_q     <= '0;
`endif
                end
                ACCESS: begin
                    if (xfer_end) begin
                        rdata_q   <= end_rdata;
                        err_q     <= end_err;
                        done_q    <= gnt_q;
                        gnt_q     <= '0;
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        ptr_q     <= ptr_nxt;
                        state_q   <= IDLE;
                    end
`ifdef APB_ARB_TIMEOUT_EN
                    else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_gnt   = gnt_q;
    assign o_done  = done_q;
    assign o_rdata = rdata_q;
    assign o_err   = err_q;
    assign PADDR   = paddr_q;
    assign PWRITE  = pwrite_q;
    assign PWDATA  = pwdata_q;
    assign PSELx   = psel_q;
    assign PENABLE = penable_q;

endmodule
